// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction memory loader:
// instruction field positions, memory geometry and loader states.
package imem_loader_pkg;

  localparam int IMEM_ADDR_W = 8;

  localparam int OPC_HI   = 15;
  localparam int OPC_LO   = 14;
  localparam int RS_HI    = 13;
  localparam int RS_LO    = 11;
  localparam int RT_HI    = 10;
  localparam int RT_LO    = 8;
  localparam int RD_HI    = 7;
  localparam int RD_LO    = 5;
  localparam int FUNCT_HI = 4;
  localparam int FUNCT_LO = 0;
  localparam int IMM_HI   = 7;
  localparam int IMM_LO   = 0;

  // Nine states, so the encoding needs four bits.
  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERR
  } ld_state_t;

  function automatic logic is_rx_state(ld_state_t s);
    return s inside {S_LEN_HI, S_LEN_LO,
                     S_DATA_HI, S_DATA_LO,
                     S_CHECK};
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream in and instruction memory write port out.
// master = host/memory side, slave = loader.
interface imem_loader_if
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W
);

  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

endinterface

// File: rtl/imem_loader_csum.sv
// Running XOR of accepted bytes with clear and enable.
// Clear wins over enable.
module imem_loader_csum
  import imem_loader_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] din,
  output logic [7:0] csum
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      csum <= 8'h00;
    end else if (en) begin
      csum <= csum ^ din;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed, XOR-checked word image into
// instruction memory while holding the CPU.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = IMEM_ADDR_W,
  parameter int MAX_WORDS = 256
)(
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  imem_loader_if.slave  bus,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

  ld_state_t         state;
  logic [15:0]       len;
  logic [15:0]       count;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wdata_q;
  logic              we_q;
  logic [7:0]        csum;
  logic              rx_ready;
  logic              xfer;
  logic [15:0]       len_in;
  logic              csum_clr;
  logic              csum_en;

  always_comb begin
    rx_ready = is_rx_state(state);
  end

  assign xfer     = bus.rx_valid & rx_ready;
  assign len_in   = {len[15:8], bus.rx_data};
  assign csum_clr = (state == S_IDLE) && start;
  // The check byte itself never folds into the sum.
  assign csum_en  = xfer && (state != S_CHECK);

  assign bus.rx_ready   = rx_ready;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;

  imem_loader_csum u_csum (
    .clk   (clk),
    .reset (reset),
    .clr   (csum_clr),
    .en    (csum_en),
    .din   (bus.rx_data),
    .csum  (csum)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      len      <= '0;
      count    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      cpu_hold <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      we_q <= 1'b0;
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_LEN_HI;
            err      <= 1'b0;
            addr_q   <= '0;
            count    <= '0;
            cpu_hold <= 1'b1;
            busy     <= 1'b1;
          end
        end
        S_LEN_HI: begin
          if (xfer) begin
            len[15:8] <= bus.rx_data;
            state     <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (xfer) begin
            len[7:0] <= bus.rx_data;
            if (len_in == 16'h0000) begin
              state <= S_CHECK;
            end else if ({1'b0, len_in} > MAX_LEN) begin
              state <= S_ERR;
              err   <= 1'b1;
            end else begin
              state <= S_DATA_HI;
            end
          end
        end
        S_DATA_HI: begin
          if (xfer) begin
            wdata_q[15:8] <= bus.rx_data;
            state         <= S_DATA_LO;
          end
        end
        S_DATA_LO: begin
          if (xfer) begin
            wdata_q[7:0] <= bus.rx_data;
            addr_q       <= count[ADDR_W-1:0];
            we_q         <= 1'b1;
            state        <= S_WRITE;
          end
        end
        S_WRITE: begin
          count <= count + 16'd1;
          if (count + 16'd1 == len) begin
            state <= S_CHECK;
          end else begin
            state <= S_DATA_HI;
          end
        end
        S_CHECK: begin
          if (xfer) begin
            if (bus.rx_data == csum) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_ERR;
              err   <= 1'b1;
            end
          end
        end
        S_DONE, S_ERR: begin
          state    <= S_IDLE;
          cpu_hold <= 1'b0;
          busy     <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes queued
// from each image, popped by a write monitor.
module tb_imem_loader;
  import imem_loader_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic cpu_hold;
  logic busy;
  logic done;
  logic err;

  imem_loader_if #(.ADDR_W(8)) bus ();

  imem_loader #(
    .ADDR_W    (8),
    .MAX_WORDS (256)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks   = 0;
  int  errors   = 0;
  int  done_cnt = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Write / done monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (bus.imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0h data %0h, none expected",
                 bus.imem_addr, bus.imem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write_addr", 32'(bus.imem_addr), 32'(e.addr));
        chk("write_data", 32'(bus.imem_wdata), 32'(e.data));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b,
                           input int gap,
                           input bit pulse_start);
    int n;
    repeat (gap) begin
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'($urandom);
      @(negedge clk);
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    start        = pulse_start;
    n = 0;
    while (!bus.rx_ready && n < 50) begin
      @(negedge clk);
      start = 1'b0;
      n++;
    end
    if (n >= 50) chk("rx_ready_timeout", 32'(n), 32'd0);
    @(negedge clk);
    start        = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'($urandom);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_on_start", 32'(busy), 32'd1);
    chk("hold_on_start", 32'(cpu_hold), 32'd1);
    chk("err_cleared", 32'(err), 32'd0);
  endtask

  task automatic run_session(input logic [15:0] len,
                             input logic [15:0] words[$],
                             input bit bad,
                             input int gmax,
                             input int start_at);
    logic [7:0] bytes[$];
    logic [7:0] x;
    bit   ok_len;
    bit   exp_done;
    int   d0;
    int   n;
    wr_t  w;
    ok_len = (len <= 16'd256);
    bytes.push_back(len[15:8]);
    bytes.push_back(len[7:0]);
    if (ok_len) begin
      for (int i = 0; i < int'(len); i++) begin
        bytes.push_back(words[i][15:8]);
        bytes.push_back(words[i][7:0]);
        w.addr = 8'(i);
        w.data = words[i];
        exp_q.push_back(w);
      end
      x = 8'h00;
      foreach (bytes[i]) x ^= bytes[i];
      bytes.push_back(bad ? ~x : x);
    end
    exp_done = ok_len && !bad;
    d0 = done_cnt;
    pulse_start();
    foreach (bytes[i])
      send_byte(bytes[i],
                gmax > 0 ? int'($urandom_range(gmax, 0)) : 0,
                i == start_at);
    n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("busy_drops", 32'(busy), 32'd0);
    chk("done_pulses", 32'(done_cnt - d0),
        exp_done ? 32'd1 : 32'd0);
    chk("err_flag", 32'(err), exp_done ? 32'd0 : 32'd1);
    chk("hold_drops", 32'(cpu_hold), 32'd0);
    chk("writes_left", 32'(exp_q.size()), 32'd0);
    if (!exp_done) begin
      repeat (5) @(negedge clk);
      chk("err_sticky", 32'(err), 32'd1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ws[$];
    int          ln;
    reset        = 1'b1;
    start        = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
    chk("rst_we", 32'(bus.imem_we), 32'd0);
    chk("rst_addr", 32'(bus.imem_addr), 32'd0);
    chk("rst_wdata", 32'(bus.imem_wdata), 32'd0);
    chk("rst_hold", 32'(cpu_hold), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Basic two-word image, good then bad checksum.
    ws = '{16'h1234, 16'hABCD};
    run_session(16'd2, ws, 1'b0, 0, -1);
    run_session(16'd2, ws, 1'b1, 0, -1);

    // Empty image, then an oversize length.
    ws = {};
    run_session(16'd0, ws, 1'b0, 0, -1);
    run_session(16'h0101, ws, 1'b0, 0, -1);

    // Same image with random source gaps.
    ws = '{16'h1234, 16'hABCD};
    run_session(16'd2, ws, 1'b0, 4, -1);

    // Reset after the third data byte.
    w_reset_test();

    // Start pulse during DATA_LO of a 4-word load.
    ws = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    run_session(16'd4, ws, 1'b0, 0, 3);

    // Random images.
    for (int s = 0; s < 6; s++) begin
      ws = {};
      ln = int'($urandom_range(6, 1));
      for (int i = 0; i < ln; i++) ws.push_back(16'($urandom));
      run_session(16'(ln), ws, ($urandom_range(3, 0) == 0), 3, -1);
    end

    // Largest image: last write lands at 255.
    ws = {};
    for (int i = 0; i < 256; i++) ws.push_back(16'($urandom));
    run_session(16'd256, ws, 1'b0, 0, -1);

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  task automatic w_reset_test();
    wr_t w;
    w.addr = 8'h00;
    w.data = 16'h1234;
    exp_q.push_back(w);
    pulse_start();
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h02, 0, 1'b0);
    send_byte(8'h12, 0, 1'b0);
    send_byte(8'h34, 0, 1'b0);
    send_byte(8'hAB, 0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_hold", 32'(cpu_hold), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_ready", 32'(bus.rx_ready), 32'd0);
    repeat (4) @(negedge clk);
    chk("rst_mid_writes", 32'(exp_q.size()), 32'd0);
  endtask

endmodule
